// File: rtl/rv32_wb_pkg.sv
// Shared types and helpers for the RV32 memory/writeback stage.
package rv32_wb_pkg;

  // Load access size as encoded by the memory stage.
  typedef enum logic [1:0] {
    LW_BYTE    = 2'b00,
    LW_HALF    = 2'b01,
    LW_WORD    = 2'b10,
    LW_ILLEGAL = 2'b11
  } load_width_t;

  // Writeback FSM: either accepting instructions or waiting on the data bus.
  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } wb_state_t;

  // Contents of the registered write port; valid=0 means the register holds a bubble.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        rd_write;
    logic [31:0] value;
  } wb_out_t;

  localparam wb_out_t WB_BUBBLE = '0;

  // A load traps when its address is not naturally aligned or its width is illegal.
  function automatic logic load_misaligned(input load_width_t width, input logic [1:0] addr_lo);
    logic bad;
    case (width)
      LW_BYTE:    bad = 1'b0;
      LW_HALF:    bad = addr_lo[0];
      LW_WORD:    bad = (addr_lo != 2'b00);
      LW_ILLEGAL: bad = 1'b1;
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rv32_load_align.sv
// Load data aligner: picks the addressed byte/half out of the bus word and
// sign- or zero-extends it to 32 bits. Purely combinational.
module rv32_load_align
  import rv32_wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  load_width_t width,
  input  logic        load_unsigned,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        byte_ext;
  logic        half_ext;

  // Select the addressed lane and extend it according to width and signedness.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    byte_ext = ~load_unsigned & byte_sel[7];
    half_ext = ~load_unsigned & half_sel[15];
    case (width)
      LW_BYTE: value = {{24{byte_ext}}, byte_sel};
      LW_HALF: value = {{16{half_ext}}, half_sel};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/rv32_mem_writeback.sv
// RV32 memory/writeback stage: retires one instruction per cycle into a
// registered register-file write port, waiting on the data bus for loads.
module rv32_mem_writeback
  import rv32_wb_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        valid_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_write_in,
  input  logic [31:0] result_in,
  input  logic        is_load_in,
  input  logic [1:0]  load_width_in,
  input  logic        load_unsigned_in,
  input  logic [1:0]  addr_lo_in,
  input  logic [31:0] mem_rdata_in,
  input  logic        mem_ready_in,
  output logic        stall_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] rd_value_out,
  output logic        writeback_flush_out,
  output logic        trap_out
);

  wb_state_t   state_q, state_d;
  logic        kill_q, kill_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic        pend_rd_write_q, pend_rd_write_d;
  load_width_t pend_width_q, pend_width_d;
  logic        pend_unsigned_q, pend_unsigned_d;
  logic [1:0]  pend_addr_q, pend_addr_d;
  wb_out_t     out_q, out_d;
  logic        trap_q, trap_d;

  load_width_t in_width;
  load_width_t align_width;
  logic [1:0]  align_addr;
  logic        align_unsigned;
  logic [31:0] aligned_value;

  assign in_width = load_width_t'(load_width_in);

  // Feed the aligner from the live inputs in IDLE and from the latched load in LOAD_WAIT.
  always_comb begin
    if (state_q == LOAD_WAIT) begin
      align_width    = pend_width_q;
      align_addr     = pend_addr_q;
      align_unsigned = pend_unsigned_q;
    end else begin
      align_width    = in_width;
      align_addr     = addr_lo_in;
      align_unsigned = load_unsigned_in;
    end
  end

  rv32_load_align u_align (
    .rdata         (mem_rdata_in),
    .addr_lo       (align_addr),
    .width         (align_width),
    .load_unsigned (align_unsigned),
    .value         (aligned_value)
  );

  // Next-state logic: accept/retire in IDLE, drain the outstanding load in LOAD_WAIT.
  always_comb begin
    state_d         = state_q;
    kill_d          = kill_q;
    pend_rd_d       = pend_rd_q;
    pend_rd_write_d = pend_rd_write_q;
    pend_width_d    = pend_width_q;
    pend_unsigned_d = pend_unsigned_q;
    pend_addr_d     = pend_addr_q;
    out_d           = out_q;
    trap_d          = 1'b0;

    case (state_q)
      IDLE: begin
        if (!stall_in) begin
          out_d = WB_BUBBLE;
          if (valid_in && !flush_in) begin
            if (!is_load_in) begin
              out_d.valid    = 1'b1;
              out_d.rd       = rd_in;
              out_d.rd_write = rd_write_in;
              out_d.value    = result_in;
            end else if (load_misaligned(in_width, addr_lo_in)) begin
              trap_d = 1'b1;
            end else if (mem_ready_in) begin
              out_d.valid    = 1'b1;
              out_d.rd       = rd_in;
              out_d.rd_write = rd_write_in;
              out_d.value    = aligned_value;
            end else begin
              state_d         = LOAD_WAIT;
              kill_d          = 1'b0;
              pend_rd_d       = rd_in;
              pend_rd_write_d = rd_write_in;
              pend_width_d    = in_width;
              pend_unsigned_d = load_unsigned_in;
              pend_addr_d     = addr_lo_in;
            end
          end
        end
      end

      LOAD_WAIT: begin
        out_d = WB_BUBBLE;
        if (flush_in) begin
          kill_d = 1'b1;
        end
        if (mem_ready_in) begin
          state_d = IDLE;
          kill_d  = 1'b0;
          if (!kill_q && !flush_in) begin
            out_d.valid    = 1'b1;
            out_d.rd       = pend_rd_q;
            out_d.rd_write = pend_rd_write_q;
            out_d.value    = aligned_value;
          end
        end
      end

      default: begin
        state_d = IDLE;
        out_d   = WB_BUBBLE;
      end
    endcase
  end

  // State, pending-load and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      kill_q          <= 1'b0;
      pend_rd_q       <= 5'd0;
      pend_rd_write_q <= 1'b0;
      pend_width_q    <= LW_BYTE;
      pend_unsigned_q <= 1'b0;
      pend_addr_q     <= 2'd0;
      out_q           <= WB_BUBBLE;
      trap_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      kill_q          <= kill_d;
      pend_rd_q       <= pend_rd_d;
      pend_rd_write_q <= pend_rd_write_d;
      pend_width_q    <= pend_width_d;
      pend_unsigned_q <= pend_unsigned_d;
      pend_addr_q     <= pend_addr_d;
      out_q           <= out_d;
      trap_q          <= trap_d;
    end
  end

  // Stall depends on state alone, so the instruction held upstream during the
  // wait is still presented in the cycle after the load completes.
  assign stall_out           = (state_q == LOAD_WAIT);
  assign rd_out              = out_q.rd;
  assign rd_write_out        = out_q.valid & out_q.rd_write & (out_q.rd != 5'd0);
  assign rd_value_out        = out_q.value;
  assign writeback_flush_out = ~out_q.valid;
  assign trap_out            = trap_q;

endmodule
